// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: edge/level latch, mask, fixed priority, ACK/EOI in-service tracking
// Optional IRQ_NEST_EN: only sources strictly above every in-service source may win arbitration.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:2]     Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] src,
    output logic [NSRC-1:0] hwint,
    output logic            irq
);

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_MASK = 3'd1;
    localparam logic [2:0] A_PEND = 3'd2;
    localparam logic [2:0] A_TRIG = 3'd3;
    localparam logic [2:0] A_VEC  = 3'd4;
    localparam logic [2:0] A_ACK  = 3'd5;
    localparam logic [2:0] A_EOI  = 3'd6;

    logic            gen;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] trig;
    logic [NSRC-1:0] pend_edge;
    logic [NSRC-1:0] isr;
    logic [NSRC-1:0] src_q;

    logic [2:0]      sel;
    logic            wr_ctrl, wr_mask, wr_pend, wr_trig, wr_ack, wr_eoi;
    logic [NSRC-1:0] w1c, ack_oh, eoi_oh;
    logic [NSRC-1:0] rise, trig_n, pend_edge_n, isr_n;
    logic [NSRC-1:0] pend, act, cand, win_oh;
    logic [2:0]      win_id;
    logic            vec_valid;
    logic [31:0]     vec_word;
    logic            unused_bits;

    assign unused_bits = ^{Addr[31:5], Din};

    // Bus write decode; ids at or above NSRC never match an ACK/EOI bit.
    always_comb begin
        sel     = Addr[4:2];
        wr_ctrl = WE && (sel == A_CTRL);
        wr_mask = WE && (sel == A_MASK);
        wr_pend = WE && (sel == A_PEND);
        wr_trig = WE && (sel == A_TRIG);
        wr_ack  = WE && (sel == A_ACK);
        wr_eoi  = WE && (sel == A_EOI);
        w1c     = '0;
        ack_oh  = '0;
        eoi_oh  = '0;
        for (int i = 0; i < NSRC; i++) begin
            w1c[i]    = wr_pend && Din[i];
            ack_oh[i] = wr_ack && (Din[2:0] == 3'(i));
            eoi_oh[i] = wr_eoi && (Din[2:0] == 3'(i));
        end
    end

    // A fresh edge beats a same-cycle clear; switching a source to level drops its latch.
    always_comb begin
        rise        = src & ~src_q;
        trig_n      = wr_trig ? Din[NSRC-1:0] : trig;
        pend_edge_n = (rise | (pend_edge & ~(w1c | ack_oh))) & trig_n;
        isr_n       = (isr | ack_oh) & ~eoi_oh;
    end

    assign pend = (pend_edge & trig) | (src & ~trig);
    assign act  = pend & mask & {NSRC{gen}};

`ifdef IRQ_NEST_EN
    // A source is blocked by any in-service source at its own index or below.
    always_comb begin
        logic seen;
        seen = 1'b0;
        cand = '0;
        for (int i = 0; i < NSRC; i++) begin
            seen    = seen | isr[i];
            cand[i] = act[i] & ~seen;
        end
    end
`else
    assign cand = act;
`endif

    always_comb begin
        logic found;
        found  = 1'b0;
        win_id = 3'd0;
        win_oh = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && !found) begin
                found     = 1'b1;
                win_id    = 3'(i);
                win_oh[i] = 1'b1;
            end
        end
        vec_valid = found;
    end

    always_comb begin
        vec_word        = '0;
        vec_word[31]    = vec_valid;
        vec_word[2:0]   = win_id;
`ifndef IRQ_NEST_EN
        vec_word[8 +: NSRC] = isr;
`endif
    end

    always_comb begin
        Dout = '0;
        case (sel)
            A_CTRL:  Dout[0]        = gen;
            A_MASK:  Dout[NSRC-1:0] = mask;
            A_PEND:  Dout[NSRC-1:0] = pend;
            A_TRIG:  Dout[NSRC-1:0] = trig;
            A_VEC:   Dout           = vec_word;
            default: Dout           = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gen       <= 1'b0;
            mask      <= '0;
            trig      <= '0;
            pend_edge <= '0;
            isr       <= '0;
            src_q     <= '0;
            hwint     <= '0;
        end else begin
            if (wr_ctrl) gen  <= Din[0];
            if (wr_mask) mask <= Din[NSRC-1:0];
            trig      <= trig_n;
            pend_edge <= pend_edge_n;
            isr       <= isr_n;
            src_q     <= src;
            hwint     <= win_oh;
        end
    end

    assign irq = |hwint;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - table-driven directed bench for irq_ctrl (NSRC = 6)
module tb_irq_ctrl;

    localparam logic [2:0] CTRL = 3'd0;
    localparam logic [2:0] MASK = 3'd1;
    localparam logic [2:0] PEND = 3'd2;
    localparam logic [2:0] TRIG = 3'd3;
    localparam logic [2:0] VEC  = 3'd4;
    localparam logic [2:0] ACK  = 3'd5;
    localparam logic [2:0] EOI  = 3'd6;

`ifdef IRQ_NEST_EN
    localparam bit NEST = 1'b1;
`else
    localparam bit NEST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  src;
    logic [5:0]  hwint;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] din;
        logic [5:0]  s;
        logic [2:0]  ra;
        logic [31:0] exp_dout;
        logic [5:0]  exp_hw;
    } vec_t;

    vec_t tbl[$];

    irq_ctrl #(.NSRC(6)) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .src   (src),
        .hwint (hwint),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] nv(input logic [31:0] nested, input logic [31:0] flat);
        return NEST ? nested : flat;
    endfunction

    function automatic void add(input logic we, input logic [2:0] wa, input logic [31:0] din,
                                input logic [5:0] s, input logic [2:0] ra,
                                input logic [31:0] exp_dout, input logic [31:0] exp_hw);
        vec_t v;
        v.we = we; v.wa = wa; v.din = din; v.s = s;
        v.ra = ra; v.exp_dout = exp_dout; v.exp_hw = exp_hw[5:0];
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input logic we, input logic [2:0] wa, input logic [31:0] d, input logic [5:0] s);
        WE   = we;
        Addr = 30'(wa);
        Din  = d;
        src  = s;
        @(posedge clk);
        #1;
        WE  = 1'b0;
        Din = '0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int a = 0; a < 8; a++) begin
            Addr = 30'(a);
            #1;
            check($sformatf("%s addr%0d", tag, a), Dout, 32'h0);
        end
        check({tag, " hwint"}, 32'(hwint), 32'h0);
        check({tag, " irq"}, 32'(irq), 32'h0);
    endtask

    initial begin
        reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0; src = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_all_zero("reset");

        // edge latch and ACK
        add(1, CTRL, 1, 0, CTRL, 1, 0);
        add(1, TRIG, 1, 0, TRIG, 1, 0);
        add(1, MASK, 1, 0, MASK, 1, 0);
        add(0, 0, 0, 6'h01, PEND, 1, 0);
        add(0, 0, 0, 0, VEC, 32'h8000_0000, 6'h01);
        add(1, ACK, 0, 0, PEND, 0, 6'h01);
        add(0, 0, 0, 0, VEC, nv(0, 32'h100), 0);
        add(1, EOI, 0, 0, VEC, 0, 0);
        // level source ignores W1C
        add(1, TRIG, 0, 0, TRIG, 0, 0);
        add(1, MASK, 2, 6'h02, PEND, 2, 0);
        add(0, 0, 0, 6'h02, PEND, 2, 6'h02);
        add(1, PEND, 32'h3F, 6'h02, PEND, 2, 6'h02);
        add(0, 0, 0, 0, PEND, 0, 0);
        // priority
        add(1, TRIG, 32'h3F, 0, TRIG, 32'h3F, 0);
        add(1, MASK, 32'h3F, 0, MASK, 32'h3F, 0);
        add(0, 0, 0, 6'h0A, PEND, 32'h0A, 0);
        add(0, 0, 0, 0, VEC, 32'h8000_0001, 6'h02);
        add(1, ACK, 1, 0, VEC, nv(0, 32'h8000_0203), 6'h02);
        add(0, 0, 0, 0, PEND, 32'h08, nv(0, 6'h08));
        add(1, EOI, 1, 0, VEC, 32'h8000_0003, nv(0, 6'h08));
        add(1, ACK, 3, 0, PEND, 0, 6'h08);
        add(1, EOI, 3, 0, VEC, 0, 0);
        // nesting
        add(1, ACK, 2, 0, VEC, nv(0, 32'h400), 0);
        add(0, 0, 0, 6'h10, PEND, 32'h10, 0);
        add(0, 0, 0, 0, PEND, 32'h10, nv(0, 6'h10));
        add(0, 0, 0, 6'h01, PEND, 32'h11, nv(0, 6'h10));
        add(0, 0, 0, 0, VEC, nv(32'h8000_0000, 32'h8000_0400), 6'h01);
        add(1, ACK, 0, 0, PEND, 32'h10, 6'h01);
        add(1, EOI, 0, 0, VEC, nv(0, 32'h8000_0404), nv(0, 6'h10));
        add(1, EOI, 2, 0, VEC, 32'h8000_0004, nv(0, 6'h10));
        add(0, 0, 0, 0, VEC, 32'h8000_0004, 6'h10);
        add(1, ACK, 4, 0, PEND, 0, 6'h10);
        add(1, EOI, 4, 0, VEC, 0, 0);
        // mask and global enable
        add(1, MASK, 32'h1F, 0, MASK, 32'h1F, 0);
        add(0, 0, 0, 6'h20, PEND, 32'h20, 0);
        add(0, 0, 0, 0, PEND, 32'h20, 0);
        add(1, MASK, 32'h3F, 0, VEC, 32'h8000_0005, 0);
        add(0, 0, 0, 0, VEC, 32'h8000_0005, 6'h20);
        add(1, CTRL, 0, 0, CTRL, 0, 6'h20);
        add(0, 0, 0, 0, PEND, 32'h20, 0);
        add(1, CTRL, 32'hFFFF_FFFF, 0, CTRL, 1, 0);
        add(0, 0, 0, 0, VEC, 32'h8000_0005, 6'h20);
        add(1, PEND, 32'h20, 0, PEND, 0, 6'h20);
        add(0, 0, 0, 0, PEND, 0, 0);
        // set/clear collision, unused address, trig change, out-of-range bits/ids
        add(1, PEND, 1, 6'h01, PEND, 1, 0);
        add(0, 0, 0, 0, VEC, 32'h8000_0000, 6'h01);
        add(1, 3'd7, 32'hFFFF_FFFF, 0, 3'd7, 0, 6'h01);
        add(1, TRIG, 32'h3E, 0, PEND, 0, 6'h01);
        add(0, 0, 0, 0, PEND, 0, 0);
        add(1, TRIG, 32'hFF, 0, TRIG, 32'h3F, 0);
        add(1, ACK, 7, 0, VEC, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].we, tbl[i].wa, tbl[i].din, tbl[i].s);
            Addr = 30'(tbl[i].ra);
            #1;
            check($sformatf("row%0d dout", i), Dout, tbl[i].exp_dout);
            check($sformatf("row%0d hwint", i), 32'(hwint), 32'(tbl[i].exp_hw));
            check($sformatf("row%0d irq", i), 32'(irq), 32'(|tbl[i].exp_hw));
        end

        // reset in the middle of pending and in-service activity
        apply(0, 0, 0, 6'h04);
        apply(0, 0, 0, 6'h00);
        apply(1, ACK, 2, 6'h00);
        apply(0, 0, 0, 6'h08);
        Addr = 30'(PEND);
        #1;
        check("midop pend", Dout, 32'h08);
        Addr = 30'(VEC);
        #1;
        check("midop vec", Dout, nv(0, 32'h8000_0403));
        reset = 1'b1;
        src   = '0;
        @(posedge clk);
        #1;
        check_all_zero("midreset");
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("postreset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Memory-mapped interrupt controller between the timer/counter peripherals (plus external sources) and CP0.
- Latches edge- or level-triggered requests per source.
- Applies a software mask and fixed priority.
- Tracks in-service sources through ACK/EOI writes.
- Drives a registered one-hot interrupt vector into CP0 HWInt.
- Sits on the system bridge with the same word-address/WE/Din/Dout slave interface as the timers.

Parameters:
NSRC, 6, number of interrupt sources (1..8); source 0 is highest priority

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
Addr  input  30  word address [31:2]; only Addr[4:2] decoded
WE  input  1  register write strobe
Din  input  32  write data
Dout  output  32  read data, combinational from Addr[4:2]
src  input  NSRC  raw requests (timer IRQ outputs, external lines), synchronous to clk
hwint  output  NSRC  one-hot winning request to CP0, registered
irq  output  1  OR of hwint

Behaviour:
Register map (Addr[4:2]):
- 0 CTRL: bit0 is the global enable GEN; other bits read as 0.
- 1 MASK: 1 = enabled.
- 2 PEND: read-only view; writes are W1C for edge sources.
- 3 TRIG: 1 = edge, 0 = level.
- 4 VEC: read-only, {valid, 28'b0, id[2:0]}.
- 5 ACK: write Din[2:0] = id.
- 6 EOI: write Din[2:0] = id.
- 7: reads 0, writes ignored.
- Bits at or above NSRC read 0 and are write-ignored.

Reset: CTRL, MASK, TRIG, edge pending, ISR, src_q and hwint all 0; irq = 0. Reset mid-operation discards pending and in-service state.

Pending:
- Edge source i: set when src[i] & ~src_q[i] (src_q = src registered one cycle). Cleared by a PEND W1C bit i, or by an ACK of i.
- Set and clear in the same cycle: set wins.
- Level source i: PEND[i] = src[i] live. W1C and ACK do not clear it.
- Changing TRIG[i] from edge to level drops the latched bit.

Arbitration:
- act = PEND & MASK, gated by GEN.
- Candidates are act bits that pass the nesting filter (see Optional Feature).
- Winner = lowest-index candidate. VEC.valid = candidate set non-empty; VEC.id = winner (0 when invalid).
- hwint <= onehot(winner) (or 0) each cycle: 1-cycle latency from the PEND/MASK/ISR change to hwint.

ACK/EOI:
- ACK id: ISR[id] <= 1; clears edge pending[id].
- EOI id: ISR[id] <= 0.
- An id >= NSRC is ignored.
- ACK and EOI are separate writes, so they cannot coincide.
- EOI of a non-in-service id has no effect.

Bus:
- WE acts on the selected register only.
- A write and a source edge in the same cycle both take effect.
- Dout reflects register state before the clock edge.

Optional Feature:
IRQ_NEST_EN
- Defined: a source is a candidate only if its index is below every set ISR bit, i.e. strictly higher priority than all in-service sources. Equal or lower priority is held pending until EOI.
- Undefined: ISR is still written by ACK/EOI and readable at Addr 4, bits [15:8]. It does not filter candidates; winner = lowest-index act bit.

Test Plan:
1. Edge latch: TRIG=0x01, MASK=0x01, GEN=1; pulse src[0] for one cycle.
   - hwint=0x01 one cycle after PEND sets; VEC=0x80000000.
   - ACK 0 → PEND[0]=0, hwint=0 next cycle.
2. Level behaviour: TRIG=0, MASK=0x02; hold src[1]=1.
   - W1C to PEND has no effect; hwint stays 0x02.
   - Drop src[1] → hwint=0 one cycle later.
3. Priority: src[3] and src[1] edges in the same cycle, all masked in → hwint=0x02, VEC.id=1.
   - ACK 1 → hwint=0x08.
4. Nesting (IRQ_NEST_EN): ACK 2; edge on src[4] → hwint=0.
   - Edge on src[0] → hwint=0x01.
   - EOI 2 after clearing src[0] → hwint=0x10.
5. Mask/enable: pending src[5] with MASK[5]=0 → hwint=0, PEND[5]=1.
   - Set MASK → hwint=0x20.
   - CTRL=0 → hwint=0.
6. Collision/reset: edge on src[0] in the same cycle as PEND W1C bit0 → PEND[0]=1.
   - Assert reset → all registers and hwint read 0 on the next cycle.
